jtag_l2_burst_bridge: RTL and testbench

//  Downstream of the JTAG TAP / debug-unit bus master in jtagL2test; consumes its word R/W bursts and drives one L2 SRAM bank.

---
 rtl/jtag_l2_burst_bridge.sv | 159 +++++++++++++++
 tb/tb_jtag_l2_burst_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_l2_burst_bridge.sv
// Turns debug-master word bursts (cmd + wdata/rdata streams) into accesses on one L2 SRAM bank.
// Latency: writes hit the SRAM the cycle they are accepted; reads return after a 2-cycle startup, then up to one beat per cycle.
// Backpressure: rdata_ready_i stalls reads through a 2-entry output FIFO; cmd_ready_o is high only when idle.
module jtag_l2_burst_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MEM_ADDR_WIDTH = 15,
    parameter int          LEN_WIDTH      = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [31:0]               cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]      cmd_len_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [31:0]               wdata_i,
    output logic                      rdata_valid_o,
    input  logic                      rdata_ready_i,
    output logic [31:0]               rdata_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    output logic [3:0]                mem_be_o,
    input  logic [31:0]               mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, READ, ERR, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      we_q;
    logic [31:0]               addr_q;
    logic [LEN_WIDTH-1:0]      cnt_q;
    logic [MEM_ADDR_WIDTH-1:0] cur_q;
    logic                      err_q;
    logic                      inflight_q;
    logic [31:0]               fifo_mem [2];
    logic                      wr_ptr_q, rd_ptr_q;
    logic [1:0]                fifo_cnt_q;

    logic [32:0] diff, word_off, end_word, limit;
    logic        reject, pop, push, rd_ok;

    // 33-bit arithmetic: bit 32 of diff flags addr below base, and the end-of-burst sum cannot overflow.
    always_comb begin
        diff     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        word_off = {1'b0, diff[31:0]} >> 2;
        end_word = word_off + 33'(cnt_q) + 33'd1;
        limit    = 33'd1 << MEM_ADDR_WIDTH;
        reject   = (addr_q[1:0] != 2'b00) || diff[32] || (end_word > limit);
    end

    assign rdata_valid_o = (fifo_cnt_q != 2'd0);
    assign rdata_o       = fifo_mem[rd_ptr_q];
    assign pop           = rdata_valid_o & rdata_ready_i;
    assign push          = inflight_q;
    // Slot freed by this cycle's pop counts, which keeps reads bubble-free under steady ready.
    assign rd_ok         = ({1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, inflight_q}) < 3'd2;
    assign mem_be_o      = 4'hF;

    always_comb begin
        state_d       = state_q;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = cur_q;
        mem_wdata_o   = 32'h0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = CHECK;
            end
            CHECK: begin
                if (reject)    state_d = ERR;
                else if (we_q) state_d = WRITE;
                else           state_d = READ;
            end
            WRITE: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_wdata_o = wdata_i;
                    if (cnt_q == '0) state_d = DRAIN;
                end
            end
            READ: begin
                if (rd_ok) begin
                    mem_req_o = 1'b1;
                    if (cnt_q == '0) state_d = DRAIN;
                end
            end
            ERR:   state_d = DONE;
            DRAIN: begin
                if (!inflight_q && fifo_cnt_q == 2'd0) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            cnt_q      <= '0;
            cur_q      <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_req_o & ~mem_we_o;
            if (cmd_ready_o && cmd_valid_i) begin
                we_q   <= cmd_we_i;
                addr_q <= cmd_addr_i;
                cnt_q  <= cmd_len_i;
                err_q  <= 1'b0;
            end
            if (state_q == CHECK) begin
                cur_q <= word_off[MEM_ADDR_WIDTH-1:0];
                err_q <= reject;
            end
            if (mem_req_o) begin
                cur_q <= cur_q + 1'b1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= 32'h0;
            fifo_mem[1] <= 32'h0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= mem_rdata_i;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_jtag_l2_burst_bridge.sv
// Directed bench for jtag_l2_burst_bridge with a behavioural 1-cycle-latency SRAM model.
module tb_jtag_l2_burst_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [7:0]  cmd_len = 8'h0;
    logic        wdata_valid = 1'b0, wdata_ready;
    logic [31:0] wdata = 32'h0;
    logic        rdata_valid, rdata_ready = 1'b0;
    logic [31:0] rdata;
    logic        done, err;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 32'h0;
    logic [3:0]  mem_be;

    jtag_l2_burst_bridge dut (
        .clk_i(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .done_o(done), .err_o(err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:32767];
    int n_chk = 0, n_fail = 0;
    int req_cnt = 0, done_cnt = 0, issued = 0, popped = 0, max_out = 0;
    logic [31:0] wbuf [0:15];
    logic [31:0] rbuf [0:15];
    int          pcyc [0:15];

    initial for (int i = 0; i < 32768; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (mem_req) begin
            req_cnt++;
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else begin
                mem_rdata <= mem[mem_addr];
                issued++;
            end
        end
        if (rdata_valid && rdata_ready) popped++;
        if (issued - popped > max_out) max_out = issued - popped;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_accept_timeout", n < 100, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int c = 0;
            wdata_valid = 1'b1; wdata = wbuf[i];
            while (!wdata_ready && c < 100) begin @(negedge clk); c++; end
            chk("wdata_timeout", c < 100, 1);
            @(negedge clk);
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int c = 0;
        while (!done && c < 200) begin @(negedge clk); c++; end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, exp_err);
    endtask

    // mode 0: ready always high; mode 1: ready one cycle in three
    task automatic collect_read(input string tag, input int n, input int mode, input logic exp_err);
        int  pops = 0, cyc = 0;
        bit  got = 0;
        while (!got && cyc < 500) begin
            @(negedge clk); cyc++;
            if (done) begin
                got = 1;
                chk({tag, "_err"}, err, exp_err);
                chk({tag, "_pops_at_done"}, pops, n);
            end else begin
                rdata_ready = (mode == 0) || (cyc % 3 == 0);
                if (rdata_valid && rdata_ready) begin
                    if (pops < 16) begin rbuf[pops] = rdata; pcyc[pops] = cyc; end
                    pops++;
                end
            end
        end
        rdata_ready = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
    endtask

    initial begin
        int snap;
        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_be", mem_be, 4'hF);
        @(negedge clk); rst_n = 1'b1;

        // 1: single write then read back
        wbuf[0] = 32'hABBA_ABBA;
        send_cmd(1'b1, 32'h0, 8'd0);
        do_beats(1);
        wait_done("t1_wr", 1'b0);
        chk("t1_mem0", mem[0], 32'hABBA_ABBA);
        send_cmd(1'b0, 32'h0, 8'd0);
        collect_read("t1_rd", 1, 0, 1'b0);
        chk("t1_rdata", rbuf[0], 32'hABBA_ABBA);

        // 2: 4-beat write at word 4, zero-bubble read back
        for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
        send_cmd(1'b1, 32'h10, 8'd3);
        do_beats(4);
        wait_done("t2_wr", 1'b0);
        for (int i = 0; i < 4; i++) chk("t2_mem", mem[4 + i], i + 1);
        send_cmd(1'b0, 32'h10, 8'd3);
        collect_read("t2_rd", 4, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk("t2_rdata", rbuf[i], i + 1);
        for (int i = 1; i < 4; i++) chk("t2_zero_bubble", pcyc[i] - pcyc[i - 1], 1);

        // 3: 8-beat read with throttled consumer
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0100 + i;
        send_cmd(1'b1, 32'h100, 8'd7);
        do_beats(8);
        wait_done("t3_wr", 1'b0);
        max_out = 0;
        send_cmd(1'b0, 32'h100, 8'd7);
        collect_read("t3_rd", 8, 1, 1'b0);
        for (int i = 0; i < 8; i++) chk("t3_rdata", rbuf[i], 32'hC0DE_0100 + i);
        chk("t3_max_buffered_le2", max_out <= 2, 1);

        // 4: rejected commands never touch the SRAM; last word is still reachable
        snap = req_cnt;
        send_cmd(1'b1, 32'h2, 8'd0);
        wait_done("t4_misalign", 1'b1);
        send_cmd(1'b0, 32'h0001_FFFC, 8'd1);
        collect_read("t4_range", 0, 0, 1'b1);
        chk("t4_no_mem_req", req_cnt - snap, 0);
        wbuf[0] = 32'h5A5A_0001;
        send_cmd(1'b1, 32'h0001_FFFC, 8'd0);
        do_beats(1);
        wait_done("t4_lastword", 1'b0);
        chk("t4_mem_last", mem[32767], 32'h5A5A_0001);

        // 5: command held during a burst is only taken once idle again
        wbuf[0] = 32'h55; wbuf[1] = 32'h66;
        send_cmd(1'b1, 32'h20, 8'd1);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h20; cmd_len = 8'd1;
        chk("t5_busy_ready", cmd_ready, 0);
        do_beats(2);
        wait_done("t5_wr", 1'b0);
        chk("t5_done_ready", cmd_ready, 0);
        @(negedge clk);
        chk("t5_idle_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        collect_read("t5_rd", 2, 0, 1'b0);
        chk("t5_rdata0", rbuf[0], 32'h55);
        chk("t5_rdata1", rbuf[1], 32'h66);

        // 6: reset in the middle of a write burst
        wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hAAAA_0002;
        send_cmd(1'b1, 32'h60, 8'd3);
        do_beats(2);
        snap = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd_ready", cmd_ready, 1);
        chk("t6_rst_wdata_ready", wdata_ready, 0);
        chk("t6_rst_mem_req", mem_req, 0);
        chk("t6_rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_done", done_cnt - snap, 0);
        chk("t6_mem24", mem[24], 32'hAAAA_0001);
        chk("t6_mem25", mem[25], 32'hAAAA_0002);
        chk("t6_mem26", mem[26], 32'h0);
        wbuf[0] = 32'h1234_5678;
        send_cmd(1'b1, 32'h80, 8'd0);
        do_beats(1);
        wait_done("t6_wr", 1'b0);
        chk("t6_mem32", mem[32], 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
